rf_multiport_sb: RTL and testbench



---
 rtl/rf_multiport_sb_pkg.sv | 22 ++
 rtl/rf_multiport_sb_if.sv | 42 ++++
 rtl/rf_multiport_sb_scoreboard.sv | 71 +++++++
 rtl/rf_multiport_sb.sv | 81 ++++++++
 tb/tb_rf_multiport_sb.sv | 281 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/rf_multiport_sb_pkg.sv
// ============================================================================
// Module  : rf_multiport_sb_pkg
// Brief   : Shared register-file types and default geometry.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

package rf_multiport_sb_pkg;

    localparam int XLEN              = 32;
    localparam int RF_DEPTH          = 32;
    localparam int RF_ADDR_WIDTH     = $clog2(RF_DEPTH);
    localparam int RF_NUM_READ_PORTS = 2;

    typedef logic [XLEN-1:0]          word_t;
    typedef logic [RF_ADDR_WIDTH-1:0] rf_addr_t;

    localparam rf_addr_t X0 = '0;

endpackage

`default_nettype wire

// File: rtl/rf_multiport_sb_if.sv
// ============================================================================
// Module  : rf_multiport_sb_if
// Brief   : Issue/writeback bus of the multiport register file.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

interface rf_multiport_sb_if #(
    parameter int XLEN       = rf_multiport_sb_pkg::XLEN,
    parameter int ADDR_WIDTH = rf_multiport_sb_pkg::RF_ADDR_WIDTH,
    parameter int NUM_RD     = rf_multiport_sb_pkg::RF_NUM_READ_PORTS
);

    logic [NUM_RD-1:0][ADDR_WIDTH-1:0] rd_addr;
    logic [NUM_RD-1:0][XLEN-1:0]       rd_data;
    logic [NUM_RD-1:0]                 rd_busy;

    logic                  wr_en;
    logic [ADDR_WIDTH-1:0] wr_addr;
    logic [XLEN-1:0]       wr_data;

    logic                  resv_en;
    logic [ADDR_WIDTH-1:0] resv_addr;

    logic                  any_pending;
    logic [ADDR_WIDTH:0]   pending_cnt;

    // Issue/writeback side
    modport master (
        output rd_addr, wr_en, wr_addr, wr_data, resv_en, resv_addr,
        input  rd_data, rd_busy, any_pending, pending_cnt
    );

    // Register-file side
    modport slave (
        input  rd_addr, wr_en, wr_addr, wr_data, resv_en, resv_addr,
        output rd_data, rd_busy, any_pending, pending_cnt
    );

endinterface

`default_nettype wire

// File: rtl/rf_multiport_sb_scoreboard.sv
// ============================================================================
// Module  : rf_scoreboard
// Brief   : Per-register pending-write bits with set-over-clear priority,
//           registered popcount, any-pending flag and per-port busy lookup.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module rf_scoreboard #(
    parameter int DEPTH      = 32,
    parameter int ADDR_WIDTH = $clog2(DEPTH),
    parameter int NUM_RD     = 2
) (
    input  wire logic                              clk,
    input  wire logic                              rst,
    input  wire logic                              i_set_en,
    input  wire logic [ADDR_WIDTH-1:0]             i_set_addr,
    input  wire logic                              i_clr_en,
    input  wire logic [ADDR_WIDTH-1:0]             i_clr_addr,
    input  wire logic [NUM_RD-1:0][ADDR_WIDTH-1:0] i_rd_addr,
    output logic      [NUM_RD-1:0]                 o_rd_busy,
    output logic                                   o_any_pending,
    output logic      [ADDR_WIDTH:0]               o_pending_cnt
);

    logic [DEPTH-1:0]    r_pending;
    logic [DEPTH-1:0]    w_pending_next;
    logic [ADDR_WIDTH:0] r_pending_cnt;
    logic [ADDR_WIDTH:0] w_cnt_next;

    // x0 can never be reserved, so its bit is tied low
    assign w_pending_next[0] = 1'b0;

    // A reservation beats a release on the same register: a newer writer exists
    generate
        for (genvar r = 1; r < DEPTH; r++) begin : g_bit
            assign w_pending_next[r] =
                (i_set_en && (i_set_addr == ADDR_WIDTH'(r))) ||
                (r_pending[r] && !(i_clr_en && (i_clr_addr == ADDR_WIDTH'(r))));
        end
    endgenerate

    always_comb begin
        w_cnt_next = '0;
        for (int i = 0; i < DEPTH; i++) begin
            w_cnt_next = w_cnt_next + (ADDR_WIDTH+1)'(w_pending_next[i]);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_pending     <= '0;
            r_pending_cnt <= '0;
        end else begin
            r_pending     <= w_pending_next;
            r_pending_cnt <= w_cnt_next;
        end
    end

    generate
        for (genvar p = 0; p < NUM_RD; p++) begin : g_busy
            assign o_rd_busy[p] = r_pending[i_rd_addr[p]];
        end
    endgenerate

    assign o_any_pending = |r_pending;
    assign o_pending_cnt = r_pending_cnt;

endmodule

`default_nettype wire

// File: rtl/rf_multiport_sb.sv
// ============================================================================
// Module  : rf_multiport_sb
// Brief   : NUM_RD-read / 1-write register file with hardwired x0 and a
//           pending-write scoreboard. Define RF_BYPASS_EN for write-through.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module rf_multiport_sb
    import rf_multiport_sb_pkg::*;
#(
    parameter int XLEN       = rf_multiport_sb_pkg::XLEN,
    parameter int DEPTH      = rf_multiport_sb_pkg::RF_DEPTH,
    parameter int ADDR_WIDTH = $clog2(DEPTH),
    parameter int NUM_RD     = rf_multiport_sb_pkg::RF_NUM_READ_PORTS
) (
    input  wire logic           clk,
    input  wire logic           rst,
    rf_multiport_sb_if.slave    bus
);

    localparam logic [ADDR_WIDTH-1:0] c_x0 = ADDR_WIDTH'(X0);

    logic [XLEN-1:0]             r_regs [DEPTH];
    logic [NUM_RD-1:0][XLEN-1:0] w_rd_data;
    logic [NUM_RD-1:0]           w_rd_busy;
    logic [NUM_RD-1:0]           w_sb_busy;
    logic                        w_wr_commit;

    assign w_wr_commit = bus.wr_en && (bus.wr_addr != c_x0);

    // Entry 0 is reset and never written, so it reads as zero
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_regs[i] <= '0;
            end
        end else if (w_wr_commit) begin
            r_regs[bus.wr_addr] <= bus.wr_data;
        end
    end

    rf_scoreboard #(
        .DEPTH      (DEPTH),
        .ADDR_WIDTH (ADDR_WIDTH),
        .NUM_RD     (NUM_RD)
    ) u_scoreboard (
        .clk           (clk),
        .rst           (rst),
        .i_set_en      (bus.resv_en),
        .i_set_addr    (bus.resv_addr),
        .i_clr_en      (bus.wr_en),
        .i_clr_addr    (bus.wr_addr),
        .i_rd_addr     (bus.rd_addr),
        .o_rd_busy     (w_sb_busy),
        .o_any_pending (bus.any_pending),
        .o_pending_cnt (bus.pending_cnt)
    );

    always_comb begin
        w_rd_data = '0;
        w_rd_busy = '0;
        for (int p = 0; p < NUM_RD; p++) begin
            w_rd_data[p] = (bus.rd_addr[p] == c_x0) ? '0 : r_regs[bus.rd_addr[p]];
            w_rd_busy[p] = w_sb_busy[p];
`ifdef RF_BYPASS_EN
            // Write-through: the writeback retires the hazard unless re-reserved now
            if (w_wr_commit && (bus.wr_addr == bus.rd_addr[p])) begin
                w_rd_data[p] = bus.wr_data;
                w_rd_busy[p] = bus.resv_en && (bus.resv_addr == bus.rd_addr[p]);
            end
`endif
        end
    end

    assign bus.rd_data = w_rd_data;
    assign bus.rd_busy = w_rd_busy;

endmodule

`default_nettype wire

// File: tb/tb_rf_multiport_sb.sv
// ============================================================================
// Module  : tb_rf_multiport_sb
// Brief   : Directed self-checking bench for rf_multiport_sb.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_rf_multiport_sb;
    import rf_multiport_sb_pkg::*;

`ifdef RF_BYPASS_EN
    localparam bit c_bypass = 1'b1;
`else
    localparam bit c_bypass = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst;
    int   checks = 0;
    int   errors = 0;

    rf_multiport_sb_if #(
        .XLEN       (XLEN),
        .ADDR_WIDTH (RF_ADDR_WIDTH),
        .NUM_RD     (RF_NUM_READ_PORTS)
    ) bus ();

    rf_multiport_sb #(
        .XLEN       (XLEN),
        .DEPTH      (RF_DEPTH),
        .ADDR_WIDTH (RF_ADDR_WIDTH),
        .NUM_RD     (RF_NUM_READ_PORTS)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        bus.wr_en     = 1'b0;
        bus.wr_addr   = '0;
        bus.wr_data   = '0;
        bus.resv_en   = 1'b0;
        bus.resv_addr = '0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        idle();
        bus.rd_addr[0] = 5'd5;
        bus.rd_addr[1] = 5'd5;
        #12;
        checks++;
        if (bus.pending_cnt !== 6'd0) begin
            errors++; $display("FAIL reset_cnt_in_rst: got %0d expected 0", bus.pending_cnt);
        end
        rst = 1'b0;
        tick();
        checks++;
        if (bus.rd_data[0] !== 32'h0 || bus.rd_data[1] !== 32'h0) begin
            errors++; $display("FAIL reset_rd_data: got %h/%h expected 0/0", bus.rd_data[0], bus.rd_data[1]);
        end
        checks++;
        if (bus.rd_busy !== 2'b00) begin
            errors++; $display("FAIL reset_busy: got %b expected 00", bus.rd_busy);
        end
        checks++;
        if (bus.pending_cnt !== 6'd0 || bus.any_pending !== 1'b0) begin
            errors++; $display("FAIL reset_pending: got cnt %0d any %b expected 0 0", bus.pending_cnt, bus.any_pending);
        end
    endtask

    task automatic test_x0_write();
        bus.wr_en     = 1'b1;
        bus.wr_addr   = 5'd0;
        bus.wr_data   = 32'hFFFF_FFFF;
        bus.resv_en   = 1'b1;
        bus.resv_addr = 5'd0;
        tick();
        idle();
        bus.rd_addr[0] = 5'd0;
        bus.rd_addr[1] = 5'd0;
        #1;
        checks++;
        if (bus.rd_data[0] !== 32'h0 || bus.rd_busy[0] !== 1'b0) begin
            errors++; $display("FAIL x0_read: got %h busy %b expected 0 busy 0", bus.rd_data[0], bus.rd_busy[0]);
        end
        checks++;
        if (bus.pending_cnt !== 6'd0 || bus.any_pending !== 1'b0) begin
            errors++; $display("FAIL x0_resv: got cnt %0d any %b expected 0 0", bus.pending_cnt, bus.any_pending);
        end
        bus.wr_en   = 1'b1;
        bus.wr_addr = 5'd31;
        bus.wr_data = 32'hAAAA_AAAA;
        tick();
        idle();
        bus.rd_addr[0] = 5'd31;
        bus.rd_addr[1] = 5'd31;
        #1;
        checks++;
        if (bus.rd_data[0] !== 32'hAAAA_AAAA || bus.rd_data[1] !== 32'hAAAA_AAAA) begin
            errors++; $display("FAIL wr31_read: got %h/%h expected aaaaaaaa/aaaaaaaa", bus.rd_data[0], bus.rd_data[1]);
        end
    endtask

    task automatic test_scoreboard();
        bus.resv_en   = 1'b1;
        bus.resv_addr = 5'd3;
        tick();
        bus.resv_addr = 5'd7;
        tick();
        idle();
        bus.rd_addr[0] = 5'd3;
        bus.rd_addr[1] = 5'd7;
        #1;
        checks++;
        if (bus.pending_cnt !== 6'd2 || bus.any_pending !== 1'b1) begin
            errors++; $display("FAIL sb_cnt2: got cnt %0d any %b expected 2 1", bus.pending_cnt, bus.any_pending);
        end
        checks++;
        if (bus.rd_busy !== 2'b11) begin
            errors++; $display("FAIL sb_busy: got %b expected 11", bus.rd_busy);
        end
        bus.wr_en   = 1'b1;
        bus.wr_addr = 5'd3;
        bus.wr_data = 32'h5555_5555;
        #1;
        checks++;
        if (bus.rd_data[0] !== (c_bypass ? 32'h5555_5555 : 32'h0) || bus.rd_busy[0] !== !c_bypass) begin
            errors++; $display("FAIL sb_wr_same_cycle: got %h busy %b expected %h busy %b",
                               bus.rd_data[0], bus.rd_busy[0], (c_bypass ? 32'h5555_5555 : 32'h0), !c_bypass);
        end
        tick();
        idle();
        #1;
        checks++;
        if (bus.rd_busy !== 2'b10 || bus.pending_cnt !== 6'd1) begin
            errors++; $display("FAIL sb_release: got busy %b cnt %0d expected 10 1", bus.rd_busy, bus.pending_cnt);
        end
        checks++;
        if (bus.rd_data[0] !== 32'h5555_5555) begin
            errors++; $display("FAIL sb_wr_data: got %h expected 55555555", bus.rd_data[0]);
        end
        bus.resv_en   = 1'b1;
        bus.resv_addr = 5'd7;
        tick();
        idle();
        #1;
        checks++;
        if (bus.pending_cnt !== 6'd1 || bus.rd_busy[1] !== 1'b1) begin
            errors++; $display("FAIL sb_re_reserve: got cnt %0d busy %b expected 1 1", bus.pending_cnt, bus.rd_busy[1]);
        end
    endtask

    task automatic test_set_wins();
        bus.resv_en   = 1'b1;
        bus.resv_addr = 5'd9;
        tick();
        idle();
        bus.rd_addr[0] = 5'd9;
        bus.rd_addr[1] = 5'd9;
        #1;
        checks++;
        if (bus.pending_cnt !== 6'd2) begin
            errors++; $display("FAIL setwin_pre_cnt: got %0d expected 2", bus.pending_cnt);
        end
        bus.resv_en   = 1'b1;
        bus.resv_addr = 5'd9;
        bus.wr_en     = 1'b1;
        bus.wr_addr   = 5'd9;
        bus.wr_data   = 32'h1234_5678;
        #1;
        checks++;
        if (bus.rd_busy[0] !== 1'b1 || bus.rd_data[0] !== (c_bypass ? 32'h1234_5678 : 32'h0)) begin
            errors++; $display("FAIL setwin_same_cycle: got %h busy %b expected %h busy 1",
                               bus.rd_data[0], bus.rd_busy[0], (c_bypass ? 32'h1234_5678 : 32'h0));
        end
        tick();
        idle();
        #1;
        checks++;
        if (bus.pending_cnt !== 6'd2 || bus.rd_busy !== 2'b11) begin
            errors++; $display("FAIL setwin_after: got cnt %0d busy %b expected 2 11", bus.pending_cnt, bus.rd_busy);
        end
        checks++;
        if (bus.rd_data[1] !== 32'h1234_5678) begin
            errors++; $display("FAIL setwin_data: got %h expected 12345678", bus.rd_data[1]);
        end
    endtask

    task automatic test_bypass();
        bus.rd_addr[0] = 5'd4;
        bus.rd_addr[1] = 5'd4;
        bus.wr_en      = 1'b1;
        bus.wr_addr    = 5'd4;
        bus.wr_data    = 32'h7FFF_FFFF;
        #1;
        checks++;
        if (bus.rd_data[0] !== (c_bypass ? 32'h7FFF_FFFF : 32'h0) ||
            bus.rd_data[1] !== (c_bypass ? 32'h7FFF_FFFF : 32'h0)) begin
            errors++; $display("FAIL bypass_same_cycle: got %h/%h expected %h",
                               bus.rd_data[0], bus.rd_data[1], (c_bypass ? 32'h7FFF_FFFF : 32'h0));
        end
        checks++;
        if (bus.rd_busy !== 2'b00) begin
            errors++; $display("FAIL bypass_busy: got %b expected 00", bus.rd_busy);
        end
        tick();
        idle();
        #1;
        checks++;
        if (bus.rd_data[1] !== 32'h7FFF_FFFF) begin
            errors++; $display("FAIL bypass_after: got %h expected 7fffffff", bus.rd_data[1]);
        end
    endtask

    task automatic test_async_reset();
        for (int a = 1; a <= 5; a++) begin
            bus.resv_en   = 1'b1;
            bus.resv_addr = 5'(a);
            tick();
        end
        idle();
        bus.rd_addr[0] = 5'd31;
        bus.rd_addr[1] = 5'd3;
        #1;
        checks++;
        if (bus.pending_cnt !== 6'd7) begin
            errors++; $display("FAIL arst_pre_cnt: got %0d expected 7", bus.pending_cnt);
        end
        bus.wr_en     = 1'b1;
        bus.wr_addr   = 5'd31;
        bus.wr_data   = 32'hDEAD_BEEF;
        bus.resv_en   = 1'b1;
        bus.resv_addr = 5'd12;
        #2;
        rst = 1'b1;
        #1;
        checks++;
        if (bus.pending_cnt !== 6'd0 || bus.any_pending !== 1'b0) begin
            errors++; $display("FAIL arst_pending: got cnt %0d any %b expected 0 0", bus.pending_cnt, bus.any_pending);
        end
        checks++;
        if (bus.rd_data[1] !== 32'h0 || bus.rd_busy !== 2'b00) begin
            errors++; $display("FAIL arst_read: got %h busy %b expected 0 busy 00", bus.rd_data[1], bus.rd_busy);
        end
        idle();
        #1;
        checks++;
        if (bus.rd_data[0] !== 32'h0) begin
            errors++; $display("FAIL arst_read31: got %h expected 0", bus.rd_data[0]);
        end
        rst = 1'b0;
        tick();
        checks++;
        if (bus.rd_data[0] !== 32'h0 || bus.pending_cnt !== 6'd0) begin
            errors++; $display("FAIL arst_after: got %h cnt %0d expected 0 0", bus.rd_data[0], bus.pending_cnt);
        end
    endtask

    initial begin
        test_reset();
        test_x0_write();
        test_scoreboard();
        test_set_wins();
        test_bypass();
        test_async_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
